// File: rtl/reorder_buffer.sv
// 15-entry in-order reorder buffer: allocates tags 1..15, captures ALU/LSB results,
// retires one ready head entry per cycle and flushes on a mispredicted branch.
module reorder_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_ce,
    input  logic [1:0]  in_decode_kind,
    input  logic [4:0]  in_decode_rd,
    input  logic        in_decode_pred_taken,
    input  logic [31:0] in_decode_pc,
    output logic [3:0]  out_decode_rob_tag,
    output logic        out_fetcher_isidle,
    input  logic [3:0]  in_decode_query_tag1,
    input  logic [3:0]  in_decode_query_tag2,
    output logic        out_query_ready1,
    output logic [31:0] out_query_value1,
    output logic        out_query_ready2,
    output logic [31:0] out_query_value2,
    input  logic [3:0]  in_alu_cdb_tag,
    input  logic [31:0] in_alu_cdb_value,
    input  logic        in_alu_cdb_taken,
    input  logic [31:0] in_alu_cdb_newpc,
    input  logic [3:0]  in_lsb_cdb_tag,
    input  logic [31:0] in_lsb_cdb_value,
    output logic [3:0]  out_reg_commit_tag,
    output logic [4:0]  out_reg_commit_rd,
    output logic [31:0] out_reg_commit_value,
    output logic [3:0]  out_lsb_commit_tag,
    output logic        out_rob_misbranch,
    output logic [31:0] out_newpc
);

    localparam logic [3:0] ZERO_TAG_ROB = 4'd0;
    localparam logic [3:0] FIRST_TAG    = 4'd1;
    localparam logic [3:0] LAST_TAG     = 4'd15;
    localparam logic [1:0] KIND_REG     = 2'd0;
    localparam logic [1:0] KIND_BR      = 2'd1;
    localparam logic [1:0] KIND_ST      = 2'd2;

    // Slot 0 exists only so 4-bit pointers index the arrays directly; it is never allocated.
    logic        busy_q  [0:15];
    logic        ready_q [0:15];
    logic [1:0]  kind_q  [0:15];
    logic [4:0]  rd_q    [0:15];
    logic        pred_q  [0:15];
    logic [31:0] pc_q    [0:15];
    logic [31:0] value_q [0:15];
    logic        taken_q [0:15];
    logic [31:0] newpc_q [0:15];

    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [3:0] count_q, count_d;

    logic not_full;
    logic alloc;
    logic commit;
    logic head_mis;
    logic flush;

    function automatic logic [3:0] next_ptr(input logic [3:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + 4'd1;
    endfunction

    assign not_full = (count_q != LAST_TAG);
    assign alloc    = in_fetcher_ce && not_full;
    assign commit   = (count_q != 4'd0) && ready_q[head_q];
    assign head_mis = (kind_q[head_q] == KIND_BR) && (taken_q[head_q] != pred_q[head_q]);
    assign flush    = commit && head_mis;

    assign out_decode_rob_tag = not_full ? tail_q : ZERO_TAG_ROB;
    assign out_fetcher_isidle = not_full;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit) begin
            head_d = next_ptr(head_q);
        end
        if (alloc) begin
            tail_d = next_ptr(tail_q);
        end
        if (alloc && !commit) begin
            count_d = count_q + 4'd1;
        end else if (!alloc && commit) begin
            count_d = count_q - 4'd1;
        end
    end

    // Operand lookup: stored result first, then same-cycle bus bypass with ALU ahead of LSB.
    function automatic logic [32:0] query(input logic [3:0] t);
        logic [32:0] r;
        r = 33'd0;
        if (t == ZERO_TAG_ROB) begin
            r = {1'b1, 32'd0};
        end else if (busy_q[t] && ready_q[t]) begin
            r = {1'b1, value_q[t]};
        end else if (in_alu_cdb_tag == t) begin
            r = {1'b1, in_alu_cdb_value};
        end else if (in_lsb_cdb_tag == t) begin
            r = {1'b1, in_lsb_cdb_value};
        end
        return r;
    endfunction

    always_comb begin
        {out_query_ready1, out_query_value1} = query(in_decode_query_tag1);
        {out_query_ready2, out_query_value2} = query(in_decode_query_tag2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                kind_q[i]  <= KIND_REG;
                rd_q[i]    <= 5'd0;
                pred_q[i]  <= 1'b0;
                pc_q[i]    <= 32'd0;
                value_q[i] <= 32'd0;
                taken_q[i] <= 1'b0;
                newpc_q[i] <= 32'd0;
            end
            out_reg_commit_tag   <= ZERO_TAG_ROB;
            out_reg_commit_rd    <= 5'd0;
            out_reg_commit_value <= 32'd0;
            out_lsb_commit_tag   <= ZERO_TAG_ROB;
            out_rob_misbranch    <= 1'b0;
            out_newpc            <= 32'd0;
        end else if (rdy) begin
            out_reg_commit_tag <= ZERO_TAG_ROB;
            out_lsb_commit_tag <= ZERO_TAG_ROB;
            out_rob_misbranch  <= 1'b0;

            if (commit) begin
                if (kind_q[head_q] == KIND_ST) begin
                    out_lsb_commit_tag <= head_q;
                end else begin
                    out_reg_commit_tag   <= head_q;
                    out_reg_commit_rd    <= rd_q[head_q];
                    out_reg_commit_value <= value_q[head_q];
                end
                if (head_mis) begin
                    out_rob_misbranch <= 1'b1;
                    out_newpc <= taken_q[head_q] ? newpc_q[head_q] : pc_q[head_q] + 32'd4;
                end
            end

            if (flush) begin
                for (int i = 0; i < 16; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
                head_q  <= FIRST_TAG;
                tail_q  <= FIRST_TAG;
                count_q <= 4'd0;
            end else begin
                // The retiring head is already ready and the tail slot is idle, so
                // neither can collide with a bus write below.
                for (int i = 1; i < 16; i++) begin
                    if (busy_q[i] && !ready_q[i]) begin
                        if (in_alu_cdb_tag == 4'(i)) begin
                            ready_q[i] <= 1'b1;
                            value_q[i] <= in_alu_cdb_value;
                            taken_q[i] <= in_alu_cdb_taken;
                            newpc_q[i] <= in_alu_cdb_newpc;
                        end else if (in_lsb_cdb_tag == 4'(i)) begin
                            ready_q[i] <= 1'b1;
                            value_q[i] <= in_lsb_cdb_value;
                        end
                    end
                end
                if (commit) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
                if (alloc) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    kind_q[tail_q]  <= (in_decode_kind == 2'd3) ? KIND_REG : in_decode_kind;
                    rd_q[tail_q]    <= in_decode_rd;
                    pred_q[tail_q]  <= in_decode_pred_taken;
                    pc_q[tail_q]    <= in_decode_pc;
                    value_q[tail_q] <= 32'd0;
                    taken_q[tail_q] <= 1'b0;
                    newpc_q[tail_q] <= 32'd0;
                end
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer; an in-order queue model
// predicts grants, query results and the commit stream checked by a monitor.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, ce;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] pc;
    logic [3:0]  grant;
    logic        isidle;
    logic [3:0]  q1, q2;
    logic        qr1, qr2;
    logic [31:0] qv1, qv2;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val;
    logic        alu_tk;
    logic [31:0] alu_np;
    logic [3:0]  lsb_tag;
    logic [31:0] lsb_val;
    logic [3:0]  c_tag;
    logic [4:0]  c_rd;
    logic [31:0] c_val;
    logic [3:0]  l_tag;
    logic        mis;
    logic [31:0] npc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_fetcher_ce(ce),
        .in_decode_kind(kind), .in_decode_rd(rd), .in_decode_pred_taken(pred),
        .in_decode_pc(pc), .out_decode_rob_tag(grant), .out_fetcher_isidle(isidle),
        .in_decode_query_tag1(q1), .in_decode_query_tag2(q2),
        .out_query_ready1(qr1), .out_query_value1(qv1),
        .out_query_ready2(qr2), .out_query_value2(qv2),
        .in_alu_cdb_tag(alu_tag), .in_alu_cdb_value(alu_val),
        .in_alu_cdb_taken(alu_tk), .in_alu_cdb_newpc(alu_np),
        .in_lsb_cdb_tag(lsb_tag), .in_lsb_cdb_value(lsb_val),
        .out_reg_commit_tag(c_tag), .out_reg_commit_rd(c_rd),
        .out_reg_commit_value(c_val), .out_lsb_commit_tag(l_tag),
        .out_rob_misbranch(mis), .out_newpc(npc)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] pc;
        bit          ready;
        logic [31:0] value;
        logic        taken;
        logic [31:0] newpc;
    } ent_t;

    typedef struct {
        logic [3:0]  reg_tag;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [3:0]  lsb_tag;
        logic        mis;
        logic [31:0] newpc;
    } ev_t;

    ent_t rob[$];
    ev_t  exp_q[$];
    int   next_tag = 1;
    int   total = 0;
    int   bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void qmodel(input logic [3:0] t, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = 32'd0;
        if (t == 4'd0) begin
            r = 1'b1;
            return;
        end
        foreach (rob[i]) begin
            if (rob[i].tag == t && rob[i].ready) begin
                r = 1'b1;
                v = rob[i].value;
                return;
            end
        end
        if (alu_tag == t) begin
            r = 1'b1;
            v = alu_val;
        end else if (lsb_tag == t) begin
            r = 1'b1;
            v = lsb_val;
        end
    endfunction

    task automatic model_step();
        ev_t  e;
        ent_t h;
        ent_t n;
        bit   flush;
        int   sz;
        if (rst) begin
            rob.delete();
            next_tag = 1;
            return;
        end
        if (!rdy) return;
        sz = rob.size();
        flush = 0;
        if (sz > 0 && rob[0].ready) begin
            h = rob.pop_front();
            e.reg_tag = (h.kind != 2'd2) ? h.tag : 4'd0;
            e.lsb_tag = (h.kind == 2'd2) ? h.tag : 4'd0;
            e.rd      = h.rd;
            e.value   = h.value;
            flush     = (h.kind == 2'd1) && (h.taken != h.pred);
            e.mis     = flush;
            e.newpc   = h.taken ? h.newpc : h.pc + 32'd4;
            exp_q.push_back(e);
        end
        if (flush) begin
            rob.delete();
            next_tag = 1;
            return;
        end
        foreach (rob[i]) begin
            if (!rob[i].ready) begin
                if (alu_tag != 0 && rob[i].tag == alu_tag) begin
                    rob[i].ready = 1;
                    rob[i].value = alu_val;
                    rob[i].taken = alu_tk;
                    rob[i].newpc = alu_np;
                end else if (lsb_tag != 0 && rob[i].tag == lsb_tag) begin
                    rob[i].ready = 1;
                    rob[i].value = lsb_val;
                end
            end
        end
        if (ce && sz < 15) begin
            n.tag = 4'(next_tag);
            n.kind = (kind == 2'd3) ? 2'd0 : kind;
            n.rd = rd;
            n.pred = pred;
            n.pc = pc;
            n.ready = 0;
            n.value = 32'd0;
            n.taken = 1'b0;
            n.newpc = 32'd0;
            rob.push_back(n);
            next_tag = (next_tag == 15) ? 1 : next_tag + 1;
        end
    endtask

    task automatic tick();
        logic        r;
        logic [31:0] v;
        #1;
        if (!rst) begin
            chk("grant", 32'(grant), (rob.size() < 15) ? 32'(next_tag) : 32'd0);
            chk("isidle", 32'(isidle), 32'(rob.size() < 15));
            qmodel(q1, r, v);
            chk("qready1", 32'(qr1), 32'(r));
            if (r) chk("qvalue1", qv1, v);
            qmodel(q2, r, v);
            chk("qready2", 32'(qr2), 32'(r));
            if (r) chk("qvalue2", qv2, v);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear();
        rst = 0; rdy = 1; ce = 0; kind = 0; rd = 0; pred = 0; pc = 0;
        q1 = 0; q2 = 0; alu_tag = 0; alu_val = 0; alu_tk = 0; alu_np = 0;
        lsb_tag = 0; lsb_val = 0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1;
        tick();
        tick();
        clear();
    endtask

    task automatic alloc1(input logic [1:0] k, input logic [4:0] r, input logic p, input logic [31:0] a);
        clear();
        ce = 1; kind = k; rd = r; pred = p; pc = a;
        tick();
    endtask

    task automatic alu1(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] np);
        clear();
        alu_tag = t; alu_val = v; alu_tk = tk; alu_np = np;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clear();
            tick();
        end
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_reg_tag", 32'(c_tag), 32'd0);
                chk("rst_lsb_tag", 32'(l_tag), 32'd0);
                chk("rst_misbranch", 32'(mis), 32'd0);
                chk("rst_newpc", npc, 32'd0);
            end else if (rdy) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("commit_reg_tag", 32'(c_tag), 32'(e.reg_tag));
                    chk("commit_lsb_tag", 32'(l_tag), 32'(e.lsb_tag));
                    chk("commit_misbranch", 32'(mis), 32'(e.mis));
                    if (e.reg_tag != 0) begin
                        chk("commit_rd", 32'(c_rd), 32'(e.rd));
                        chk("commit_value", c_val, e.value);
                    end
                    if (e.mis) chk("commit_newpc", npc, e.newpc);
                end else begin
                    chk("idle_reg_tag", 32'(c_tag), 32'd0);
                    chk("idle_lsb_tag", 32'(l_tag), 32'd0);
                    chk("idle_misbranch", 32'(mis), 32'd0);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] cand[$];
        int ce_pct, cdb_pct, r;
        clear();
        @(negedge clk);
        do_reset();

        // single reg-write round trip
        alloc1(2'd0, 5'd5, 1'b0, 32'h0);
        alu1(4'd1, 32'h1234, 1'b0, 32'h0);
        idle(3);

        // fill, block at full, wrap to tag 1
        do_reset();
        for (int i = 0; i < 15; i++) alloc1(2'd0, 5'(i + 1), 1'b0, 32'(i * 4));
        alloc1(2'd0, 5'd9, 1'b0, 32'h0);
        alu1(4'd1, 32'hAA, 1'b0, 32'h0);
        alloc1(2'd3, 5'd7, 1'b0, 32'h80);
        alloc1(2'd0, 5'd8, 1'b0, 32'h84);
        idle(2);

        // out-of-order completion retires in order
        do_reset();
        alloc1(2'd0, 5'd1, 1'b0, 32'h10);
        alloc1(2'd0, 5'd2, 1'b0, 32'h14);
        alu1(4'd2, 32'h22, 1'b0, 32'h0);
        idle(2);
        alu1(4'd1, 32'h11, 1'b0, 32'h0);
        idle(3);

        // mispredicted branch flushes younger entries
        do_reset();
        alloc1(2'd1, 5'd1, 1'b0, 32'h40);
        alloc1(2'd0, 5'd2, 1'b0, 32'h44);
        alloc1(2'd0, 5'd3, 1'b0, 32'h48);
        alu1(4'd1, 32'h44, 1'b1, 32'h100);
        idle(1);
        alloc1(2'd0, 5'd4, 1'b0, 32'h100);
        idle(1);

        // same-cycle bypass and tag 0 query, then a store commit
        do_reset();
        alloc1(2'd0, 5'd1, 1'b0, 32'h0);
        alloc1(2'd0, 5'd2, 1'b0, 32'h4);
        alloc1(2'd0, 5'd3, 1'b0, 32'h8);
        clear();
        alu_tag = 4'd3; alu_val = 32'd7; q1 = 4'd3; q2 = 4'd0;
        tick();
        do_reset();
        alloc1(2'd2, 5'd0, 1'b0, 32'h200);
        clear();
        lsb_tag = 4'd1; lsb_val = 32'h300;
        tick();
        idle(3);

        // randomized traffic
        ce_pct = 80;
        cdb_pct = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) begin
                r = $urandom_range(0, 2);
                ce_pct  = (r == 0) ? 30 : (r == 1) ? 80 : 97;
                cdb_pct = (r == 2) ? 15 : 60;
            end
            clear();
            rst = ($urandom_range(0, 599) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            ce  = ($urandom_range(0, 99) < ce_pct);
            r = $urandom_range(0, 11);
            kind = (r < 6) ? 2'd0 : (r == 6) ? 2'd3 : (r < 10) ? 2'd2 : 2'd1;
            rd = 5'($urandom);
            pred = 1'($urandom);
            pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            q1 = 4'($urandom_range(0, 15));
            q2 = 4'($urandom_range(0, 15));
            cand.delete();
            foreach (rob[i]) if (!rob[i].ready) cand.push_back(rob[i].tag);
            if (cand.size() > 0 && $urandom_range(0, 99) < cdb_pct) begin
                alu_tag = cand[$urandom_range(0, cand.size() - 1)];
                alu_val = $urandom;
                alu_tk  = 1'($urandom);
                alu_np  = $urandom;
            end
            cand.delete();
            foreach (rob[i])
                if (!rob[i].ready && rob[i].kind != 2'd1 && rob[i].tag != alu_tag)
                    cand.push_back(rob[i].tag);
            if (cand.size() > 0 && $urandom_range(0, 99) < cdb_pct) begin
                lsb_tag = cand[$urandom_range(0, cand.size() - 1)];
                lsb_val = $urandom;
            end
            tick();
        end
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
